// File: rtl/i2c_target_rx.sv
// Write-only I2C target: oversampled SCL/SDA, START/STOP detection, 8-bit address match, ACK drive.
// Optional GENERAL_CALL_EN also ACKs address 8'h00 and adds the General_call output.
module i2c_target_rx #(
  parameter logic [7:0] SLAVE_ADDR = 8'h5A,
  parameter bit         LSB_FIRST  = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SCL,
  inout  wire        SDA,
  output logic [7:0] Data,
  output logic       Data_valid,
  output logic       Addr_match,
  output logic       Busy,
`ifdef GENERAL_CALL_EN
  output logic       General_call,
`endif
  output logic       Stop_det
);

  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE} state_e;

  state_e      state_q, state_d;
  logic        scl_s1_q, scl_s_q, scl_p_q;
  logic        sda_s1_q, sda_s_q, sda_p_q;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        dv_q, dv_d;
  logic        match_q, match_d;
  logic        busy_q, busy_d;
  logic        stop_q, stop_d;
  logic        oe_q, oe_d;
`ifdef GENERAL_CALL_EN
  logic        gc_q, gc_d;
`endif

  logic       scl_rise, scl_fall, start_c, stop_c, addr_hit;
  logic [3:0] cnt_inc;
  logic [7:0] shift_in;

  // Conditions require SCL high on both current and previous sample.
  assign scl_rise = scl_s_q & ~scl_p_q;
  assign scl_fall = ~scl_s_q & scl_p_q;
  assign start_c  = scl_s_q & scl_p_q & sda_p_q & ~sda_s_q;
  assign stop_c   = scl_s_q & scl_p_q & ~sda_p_q & sda_s_q;
  assign cnt_inc  = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
  assign shift_in = LSB_FIRST ? {sda_s_q, shift_q[7:1]} : {shift_q[6:0], sda_s_q};
`ifdef GENERAL_CALL_EN
  assign addr_hit = (shift_q == SLAVE_ADDR) || (shift_q == 8'h00);
`else
  assign addr_hit = (shift_q == SLAVE_ADDR);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    match_d = match_q;
    busy_d  = busy_q;
    stop_d  = 1'b0;
    oe_d    = oe_q;
`ifdef GENERAL_CALL_EN
    gc_d    = gc_q;
`endif
    if (stop_c) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      match_d = 1'b0;
      busy_d  = 1'b0;
      stop_d  = 1'b1;
`ifdef GENERAL_CALL_EN
      gc_d    = 1'b0;
`endif
    end else if (start_c) begin
      state_d = ADDR;
      oe_d    = 1'b0;
      match_d = 1'b0;
      busy_d  = 1'b1;
      cnt_d   = '0;
`ifdef GENERAL_CALL_EN
      gc_d    = 1'b0;
`endif
    end else begin
      unique case (state_q)
        ADDR, DATA: begin
          if (scl_rise) begin
            shift_d = shift_in;
            cnt_d   = cnt_inc;
          end else if (scl_fall && cnt_q == 4'd8) begin
            if (state_q == DATA) begin
              data_d  = shift_q;
              dv_d    = 1'b1;
              oe_d    = 1'b1;
              state_d = DATA_ACK;
            end else if (addr_hit) begin
              oe_d    = 1'b1;
              state_d = ADDR_ACK;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        // The address byte is still in shift_q here, so the match source is read off it.
        ADDR_ACK: begin
          if (scl_fall) begin
            oe_d    = 1'b0;
            match_d = 1'b1;
            cnt_d   = '0;
            state_d = DATA;
`ifdef GENERAL_CALL_EN
            gc_d    = (shift_q == 8'h00) && (SLAVE_ADDR != 8'h00);
`endif
          end
        end
        DATA_ACK: begin
          if (scl_fall) begin
            oe_d    = 1'b0;
            cnt_d   = '0;
            state_d = DATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      scl_s1_q <= 1'b1;
      scl_s_q  <= 1'b1;
      scl_p_q  <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s_q  <= 1'b1;
      sda_p_q  <= 1'b1;
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      dv_q     <= 1'b0;
      match_q  <= 1'b0;
      busy_q   <= 1'b0;
      stop_q   <= 1'b0;
      oe_q     <= 1'b0;
`ifdef GENERAL_CALL_EN
      gc_q     <= 1'b0;
`endif
    end else begin
      scl_s1_q <= SCL;
      scl_s_q  <= scl_s1_q;
      scl_p_q  <= scl_s_q;
      sda_s1_q <= SDA;
      sda_s_q  <= sda_s1_q;
      sda_p_q  <= sda_s_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      dv_q     <= dv_d;
      match_q  <= match_d;
      busy_q   <= busy_d;
      stop_q   <= stop_d;
      oe_q     <= oe_d;
`ifdef GENERAL_CALL_EN
      gc_q     <= gc_d;
`endif
    end
  end

  // Gating with RST releases the line combinationally, even mid-ACK.
  assign SDA        = (oe_q && !RST) ? 1'b0 : 1'bz;
  assign Data       = data_q;
  assign Data_valid = dv_q;
  assign Addr_match = match_q;
  assign Busy       = busy_q;
  assign Stop_det   = stop_q;
`ifdef GENERAL_CALL_EN
  assign General_call = gc_q;
`endif

endmodule

// File: tb/tb_i2c_target_rx.sv
// Self-checking bench for i2c_target_rx: vector table, hand-written corner sequences and
// randomized transactions checked against a transaction-level reference model.
module tb_i2c_target_rx;
  localparam logic [7:0]  SLAVE_ADDR = 8'h5A;
  localparam bit          LSB_FIRST  = 1'b1;
  localparam int unsigned Q          = 5;
`ifdef GENERAL_CALL_EN
  localparam bit GC_ON = 1'b1;
`else
  localparam bit GC_ON = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST;
  logic       SCL;
  logic       sda_m;
  wire        SDA;
  logic [7:0] Data;
  logic       Data_valid, Addr_match, Busy, Stop_det;
`ifdef GENERAL_CALL_EN
  logic       General_call;
`endif

  assign SDA = sda_m ? 1'bz : 1'b0;
  pullup (SDA);

  always #5 CLK = ~CLK;

  i2c_target_rx #(.SLAVE_ADDR(SLAVE_ADDR), .LSB_FIRST(LSB_FIRST)) dut (
    .CLK(CLK), .RST(RST), .SCL(SCL), .SDA(SDA), .Data(Data), .Data_valid(Data_valid),
    .Addr_match(Addr_match), .Busy(Busy),
`ifdef GENERAL_CALL_EN
    .General_call(General_call),
`endif
    .Stop_det(Stop_det));

  int unsigned errors = 0, checks = 0;
  logic [7:0]  got_q[$];
  int unsigned stop_cnt = 0, dv_double = 0, sd_double = 0, bad_drive = 0;
  logic        dv_prev = 1'b0, sd_prev = 1'b0;
  bit          ack_window = 1'b0;

  always @(negedge CLK) begin
    if (Data_valid) got_q.push_back(Data);
    if (Data_valid && dv_prev) dv_double++;
    if (Stop_det) stop_cnt++;
    if (Stop_det && sd_prev) sd_double++;
    dv_prev = Data_valid;
    sd_prev = Stop_det;
    if (SCL && sda_m && !ack_window && !RST && SDA === 1'b0) bad_drive++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int unsigned n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;  wait_clk(Q);
    SCL = 1'b1; wait_clk(2 * Q);
    SCL = 1'b0; wait_clk(Q);
  endtask

  task automatic send_bits(input logic [7:0] b, input int unsigned nb);
    for (int unsigned i = 0; i < nb; i++) send_bit(LSB_FIRST ? b[i] : b[7 - i]);
  endtask

  // Returns 1 if SDA was low for the whole ACK high phase, 0 if never low, 2 if mixed.
  task automatic ack_bit(output int unsigned code);
    int unsigned lows;
    ack_window = 1'b1;
    sda_m = 1'b1; wait_clk(Q);
    SCL = 1'b1;
    lows = 0;
    for (int unsigned i = 0; i < 2 * Q; i++) begin
      @(negedge CLK);
      if (SDA === 1'b0) lows++;
    end
    SCL = 1'b0; wait_clk(Q);
    ack_window = 1'b0;
    code = (lows == 2 * Q) ? 1 : ((lows == 0) ? 0 : 2);
  endtask

  task automatic send_byte(input logic [7:0] b, output int unsigned code);
    send_bits(b, 8);
    ack_bit(code);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(Q);
    SCL = 1'b1;   wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    SCL = 1'b0;   wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(Q);
    SCL = 1'b1;   wait_clk(Q);
    sda_m = 1'b1; wait_clk(2 * Q);
  endtask

  function automatic bit model_match(input logic [7:0] a);
    return (a == SLAVE_ADDR) || (GC_ON && a == 8'h00);
  endfunction

  task automatic run_txn(input string tag, input logic [7:0] addr, input int unsigned n,
                         input logic [3:0][7:0] d, input int unsigned partial, input bit exp_match);
    logic [7:0]  exp_q[$];
    int unsigned code, stops0;
    got_q.delete();
    stops0 = stop_cnt;
    i2c_start();
    check({tag, ".busy_start"}, Busy, 1);
    send_byte(addr, code);
    check({tag, ".addr_ack"}, code, exp_match);
    check({tag, ".addr_match"}, Addr_match, exp_match);
`ifdef GENERAL_CALL_EN
    check({tag, ".general_call"}, General_call, exp_match && addr == 8'h00);
`endif
    for (int unsigned i = 0; i < n; i++) begin
      send_byte(d[i], code);
      check({tag, ".data_ack"}, code, exp_match);
      if (exp_match) exp_q.push_back(d[i]);
    end
    if (partial != 0) send_bits(8'($urandom), partial);
    i2c_stop();
    check({tag, ".busy_end"}, Busy, 0);
    check({tag, ".match_end"}, Addr_match, 0);
    check({tag, ".stop_pulses"}, stop_cnt - stops0, 1);
    check({tag, ".byte_count"}, got_q.size(), exp_q.size());
    for (int unsigned i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, ".byte"}, got_q[i], exp_q[i]);
    if (exp_q.size() > 0) check({tag, ".data_hold"}, Data, exp_q[exp_q.size() - 1]);
  endtask

  typedef struct packed {
    logic [7:0]      addr;
    logic [2:0]      n;
    logic [3:0][7:0] d;
    logic [3:0]      partial;
    logic            exp_match;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int unsigned code, stops0, sel, nb, pb;
    logic [7:0]      ra;
    logic [3:0][7:0] rd;

    vecs[0] = '{8'h5A, 3'd1, {8'h00, 8'h00, 8'h00, 8'hC3}, 4'd0, 1'b1};
    vecs[1] = '{8'h33, 3'd1, {8'h00, 8'h00, 8'h00, 8'hC3}, 4'd0, 1'b0};
    vecs[2] = '{8'h5A, 3'd3, {8'h00, 8'h80, 8'hFF, 8'h01}, 4'd0, 1'b1};
    vecs[3] = '{8'h00, 3'd1, {8'h00, 8'h00, 8'h00, 8'h55}, 4'd0, GC_ON};
    vecs[4] = '{8'h5A, 3'd2, {8'h00, 8'h00, 8'h3C, 8'hA5}, 4'd5, 1'b1};
    vecs[5] = '{8'h5B, 3'd2, {8'h00, 8'h00, 8'h12, 8'h34}, 4'd3, 1'b0};

    RST = 1'b1; SCL = 1'b1; sda_m = 1'b1;
    wait_clk(5);
    check("rst.sda_released", SDA === 1'b1, 1);
    check("rst.outputs", {Data, Data_valid, Addr_match, Busy, Stop_det}, 0);
    RST = 1'b0;
    wait_clk(50);
    check("idle.sda_released", SDA === 1'b1, 1);
    check("idle.outputs", {Data, Data_valid, Addr_match, Busy, Stop_det}, 0);

    for (int unsigned v = 0; v < 6; v++)
      run_txn($sformatf("vec%0d", v), vecs[v].addr, vecs[v].n, vecs[v].d,
              vecs[v].partial, vecs[v].exp_match);

    // Partial byte dropped by a repeated START, then a full transaction.
    got_q.delete();
    stops0 = stop_cnt;
    i2c_start();
    send_byte(SLAVE_ADDR, code);
    check("rs.addr_ack1", code, 1);
    send_bits(8'hF0, 4);
    i2c_start();
    check("rs.match_cleared", Addr_match, 0);
    check("rs.busy_kept", Busy, 1);
    send_byte(SLAVE_ADDR, code);
    check("rs.addr_ack2", code, 1);
    send_byte(8'h77, code);
    check("rs.data_ack", code, 1);
    i2c_stop();
    check("rs.byte_count", got_q.size(), 1);
    if (got_q.size() > 0) check("rs.byte", got_q[0], 8'h77);
    check("rs.stop_pulses", stop_cnt - stops0, 1);

    // Reset asserted while the target is holding the address ACK.
    i2c_start();
    send_bits(SLAVE_ADDR, 8);
    ack_window = 1'b1;
    sda_m = 1'b1; wait_clk(Q);
    SCL = 1'b1;   wait_clk(Q);
    check("rstack.driven", SDA === 1'b0, 1);
    RST = 1'b1;
    #1;
    check("rstack.sda_released", SDA === 1'b1, 1);
    check("rstack.outputs", {Data_valid, Addr_match, Busy, Stop_det}, 0);
    wait_clk(3);
    RST = 1'b0;
    ack_window = 1'b0;
    wait_clk(10);
    check("rstack.idle_after", {Busy, Addr_match}, 0);
    run_txn("post_rst", SLAVE_ADDR, 1, {8'h00, 8'h00, 8'h00, 8'h9E}, 0, 1'b1);

    for (int unsigned k = 0; k < 20; k++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: ra = SLAVE_ADDR;
        1: ra = 8'h00;
        2: ra = SLAVE_ADDR ^ (8'h01 << $urandom_range(0, 7));
        default: ra = 8'($urandom);
      endcase
      rd = $urandom;
      nb = $urandom_range(0, 4);
      pb = $urandom_range(0, 7);
      run_txn($sformatf("rnd%0d", k), ra, nb, rd, pb, model_match(ra));
    end

    check("dv_single_pulse", dv_double, 0);
    check("stop_single_pulse", sd_double, 0);
    check("no_drive_outside_ack", bad_drive, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_target_rx.md
Name: i2c_target_rx

Overview:
- Write-only I2C target (receiver end) for the team's bit-banged I2C write master.
- Oversamples SCL/SDA on the system clock, detects START/STOP, matches an 8-bit address, ACKs by pulling SDA low, and delivers each received data byte with a one-cycle valid strobe.
- Sits between the board I2C pins and the fabric register logic; no clock stretching, no read support.

Parameters:
- SLAVE_ADDR, 8'h5A, full 8-bit address compared against the first byte after START; there is no separate R/W bit.
- LSB_FIRST, 1, 1 = bits shifted in LSB first (matches team master), 0 = MSB first.

Ports:
- CLK  input  1  system clock, at least 8x SCL frequency.
- RST  input  1  asynchronous active-high reset.
- SCL  input  1  I2C clock from master.
- SDA  inout  1  I2C data; driven only as 1'b0 (ACK), otherwise 1'bZ.
- Data  output  8  last received data byte.
- Data_valid  output  1  one-CLK pulse when Data updates.
- Addr_match  output  1  high from address ACK until STOP or START.
- Busy  output  1  high between START and STOP.
- Stop_det  output  1  one-CLK pulse on STOP.

Behaviour:
- Reset values: Data=0, Data_valid=0, Addr_match=0, Busy=0, Stop_det=0, SDA released (Z). Reset releases SDA asynchronously, even mid-ACK.
- Input conditioning:
  - SCL and SDA each pass through a 2-flop synchronizer, plus a previous-value flop.
  - Edges are detected on the synchronized values.
  - Pin-to-detect latency is 3 CLK cycles.
- Conditions, with SCL_s high:
  - START: SDA_s falls.
  - STOP: SDA_s rises.
  - Both are evaluated before bit sampling and override it in the same cycle.
- States: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
- IDLE: START -> ADDR, Busy=1, bit counter=0.
- ADDR:
  - Sample SDA_s on each SCL_s rise into the shift register (direction per LSB_FIRST); counter++.
  - On the 8th SCL fall: if shift==SLAVE_ADDR -> ADDR_ACK and drive SDA low; else -> IGNORE.
- ADDR_ACK:
  - Hold SDA low through the 9th SCL high.
  - On the 9th SCL fall: release SDA, Addr_match=1, counter=0 -> DATA.
- DATA:
  - Sample 8 bits as in ADDR.
  - On the 8th SCL fall: Data<=shift, Data_valid=1 for one CLK, drive SDA low -> DATA_ACK.
- DATA_ACK: on the 9th SCL fall, release SDA, counter=0 -> DATA. Supports unlimited bytes per transaction.
- IGNORE: never drive SDA; wait for START or STOP.
- START in any non-IDLE state (repeated START):
  - Release SDA and clear Addr_match.
  - Counter=0 -> ADDR; Busy stays 1.
- STOP in any state:
  - Release SDA; Addr_match=0, Busy=0, Stop_det pulses one cycle -> IDLE.
  - A partial byte (<8 bits) is discarded; no Data_valid.
- SDA is never driven while SCL_s is high except during the ACK bit.
- The SDA drive change happens only on a detected SCL fall, so there are no glitches on the data line.
- Bit counter is 4 bits and saturates; it never wraps inside a byte.

Optional Feature:
- Macro GENERAL_CALL_EN.
- Defined: address byte 8'h00 is also ACKed and its data bytes are delivered. Adds output General_call (1 bit, reset 0), high alongside Addr_match when the match was via 8'h00.
- Undefined: only SLAVE_ADDR matches. 8'h00 goes to IGNORE. No General_call port exists.

Test Plan:
- RST held, SCL=SDA=1 -> SDA=Z, all outputs 0; release RST, idle 50 cycles -> no change.
- START, addr 8'h5A LSB-first, data 8'hC3, STOP -> SDA low exactly during each 9th SCL clock; Data=8'hC3; Data_valid one pulse; Stop_det one pulse; Busy low after STOP.
- START, addr 8'h33 -> SDA never driven; no Data_valid; Addr_match stays 0.
- START, 8'h5A, data 8'h01, 8'hFF, 8'h80 -> three Data_valid pulses with those values in order; three data ACKs.
- START, 8'h5A, 4 data bits, then repeated START, 8'h5A, 8'h77, STOP -> partial byte dropped; single Data_valid with 8'h77.
- Assert RST while SDA driven low during ACK -> SDA goes Z within the same cycle; state IDLE.
